line_buffer_ring: RTL and testbench
===================================

// Module: line_buffer_ring
// PURPOSE
// - Parametrised successor line-buffer block: N_BUFFS line buffers (default 2) filled from the frame buffer, one display read port.
// - Fill requests are pulses, queued per buffer and served round-robin; each fill takes a frame-buffer row base address.
// - A display read of a buffer always wins over a fill write to it: the fill stalls instead of corrupting data.
// - Sits between the VGA timing/line controller and the frame-buffer RAM interface.
// PARAMETERS
// - N_BUFFS          2    number of line buffers (>=2)
// - COLR_PXL_WIDTH   12   bits per tile colour
// - WIDTH_PX         640  active pixels per line
// - TILE_WIDTH       4    pixels per tile
// - TILES_PER_ROW    5    tiles per frame-buffer word
// - FBUFF_ADDR_WIDTH 12   frame-buffer address width
// - FBUFF_DATA_WIDTH TILES_PER_ROW*COLR_PXL_WIDTH   frame-buffer word width
// - TILE_PER_LINE    WIDTH_PX/TILE_WIDTH (derived); LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE)
// - Elaboration error if TILE_PER_LINE % TILES_PER_ROW != 0 or N_BUFFS < 2.
// PORTS
// - clk_i             in  1                 single clock, rising edge
// - rstn_i            in  1                 asynchronous reset, active low
// - fill_req_i        in  N_BUFFS           1-cycle pulse per buffer: request fill
// - fill_row_addr_i   in  FBUFF_ADDR_WIDTH  row base address, sampled with fill_req_i
// - fill_done_o       out N_BUFFS           1-cycle pulse: buffer k fill complete
// - fill_busy_o       out 1                 high while a fill is active
// - buff_sel_i        in  N_BUFFS           display-read select (one-hot; lowest set bit wins)
// - disp_pxl_id_i     in  LBUFF_ADDR_WIDTH  tile index to read
// - disp_pxl_o        out COLR_PXL_WIDTH    tile colour, 1 cycle after disp_pxl_id_i
// - fill_stall_o      out 1                 write stalled by display read this cycle
// - fbuff_en_o        out 1                 frame-buffer enable, tied 1
// - fbuff_rd_req_o    out 1                 1-cycle read request pulse
// - fbuff_addr_o      out FBUFF_ADDR_WIDTH  read address, stable from req until rsp
// - fbuff_rd_rsp_i    in  1                 1-cycle pulse: fbuff_data_i valid (>=1 cycle after req)
// - fbuff_data_i      in  FBUFF_DATA_WIDTH  frame-buffer word
// BEHAVIOUR
// - Reset values: all outputs 0 except fbuff_en_o=1; pending queue, row addresses, counters, RR pointer cleared; FSM=IDLE.
// - Queue: fill_req_i[k] sets pending[k] and stores fill_row_addr_i in slot k (re-request before grant overwrites the address).
//   Several bits in one cycle are all queued. A request for the buffer being filled is queued for after it.
// - Arbitration (IDLE): grant first pending index at or after rr_ptr (wrapping); clear pending[k]; rr_ptr <= k+1 mod N_BUFFS.
// - FSM IDLE -> REQ: fbuff_addr <= row_addr[k], tile_cnt=0, wr_addr=0.
// - REQ: fbuff_rd_req_o=1 for exactly one cycle -> WAIT.
// - WAIT: on fbuff_rd_rsp_i latch fbuff_data_i -> WRITE. Rsp outside WAIT is ignored.
// - WRITE: write tile data[tile_cnt*COLR_PXL_WIDTH +: COLR_PXL_WIDTH] to buffer k at wr_addr; tile 0 first.
//   Both counters advance per unstalled write.
//   After tile TILES_PER_ROW-1: if wr_addr==TILE_PER_LINE-1 -> DONE, else fbuff_addr+1 -> REQ.
// - Stall: if buff_sel_i selects buffer k in WRITE, no write occurs and counters hold. fill_stall_o=1 that cycle.
// - DONE: fill_done_o[k]=1 one cycle -> IDLE. fill_busy_o=1 in REQ/WAIT/WRITE/DONE.
// - Read path: RAM address = disp_pxl_id_i when selected, else write address. buff_sel registered 1 cycle to align with RAM latency.
//   disp_pxl_o = douta[sel_q] or 0 when sel_q==0.
// - Counters wrap: fbuff_addr wraps at 2**FBUFF_ADDR_WIDTH.
// - Reset mid-fill aborts: no done pulse, queue lost, buffer contents partial/undefined.
// - Default throughput: 32 words/line; min fill = 32*(1 req + 1 rsp wait + 5 writes) + 1 done cycles.
// STRUCTURE
// - Package line_buff_pkg: state enum {IDLE,REQ,WAIT,WRITE,DONE}, derived localparams, rr_next() function (first set bit from pointer).
// - Sub-module: lbuff_ram_bank wraps N_BUFFS xilinx_single_port_ram instances (generate), address mux and read mux.
// - Top holds queue, arbiter, FSM and counters.
// TESTING
// - Reset, then idle 10 cycles -> all outputs 0 except fbuff_en_o=1; no fbuff_rd_req_o.
// - fill_req_i=2'b01, addr 0x040, rsp 2 cycles after each req, data tile t = 0x100*word+t
//   -> 32 reqs at 0x040..0x05F; fill_done_o=2'b01 once; reads of ids 0..159 return expected values 1 cycle later.
// - fill_req_i=2'b11 same cycle, rr_ptr=0 -> buffer 0 then buffer 1 filled; next simultaneous pair served 0,1 again (RR pointer wraps).
// - Fill buffer 1 while buff_sel_i=2'b10 for 7 cycles mid-WRITE -> fill_stall_o high 7 cycles; done delayed exactly 7 cycles; contents correct.
// - Reset asserted in WAIT of word 10 -> outputs cleared asynchronously; no fill_done_o; late rsp ignored; new request completes normally.
// - N_BUFFS=3, TILES_PER_ROW=4, COLR_PXL_WIDTH=8 -> 40 reqs per line; buff_sel_i=3'b110 reads buffer 1.

Source files
------------

// File: rtl/line_buff_pkg.sv
// Shared types and helpers for the line-buffer ring: fill FSM states and
// the round-robin pick used by the fill arbiter.
package line_buff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WRITE,
        DONE
    } fill_state_e;

    localparam int MAX_BUFFS = 32;
    localparam int RR_W      = $clog2(MAX_BUFFS);

    // First set bit of pend at or after ptr, wrapping at n. Returns ptr when nothing is set.
    function automatic int unsigned rr_next(input logic [MAX_BUFFS-1:0] pend,
                                            input int unsigned          ptr,
                                            input int unsigned          n);
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_BUFFS; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && pend[idx[RR_W-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lbuff_ram_bank.sv
// N line-buffer RAMs with display/fill address steering and a registered read select.
// Read data appears one cycle after the display address; writes never stall here.
module lbuff_ram_bank #(
    parameter int N_BUFFS          = 2,
    parameter int COLR_PXL_WIDTH   = 12,
    parameter int TILE_PER_LINE    = 160,
    parameter int LBUFF_ADDR_WIDTH = 8,
    parameter int BUF_W            = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_BUFFS-1:0]          sel_oh_i,
    input  logic [LBUFF_ADDR_WIDTH-1:0] disp_id_i,
    input  logic                        wr_en_i,
    input  logic [BUF_W-1:0]            wr_buf_i,
    input  logic [LBUFF_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [COLR_PXL_WIDTH-1:0]   wr_dat_i,
    output logic [COLR_PXL_WIDTH-1:0]   disp_pxl_o
);

    logic [COLR_PXL_WIDTH-1:0] douta [N_BUFFS];
    logic [N_BUFFS-1:0]        sel_q;
    logic [N_BUFFS-1:0]        sel_d;

    for (genvar k = 0; k < N_BUFFS; k++) begin : g_buf
        logic [LBUFF_ADDR_WIDTH-1:0] addr;
        logic                        we;

        // A selected buffer is owned by the display; the fill side stalls on it.
        assign addr = sel_oh_i[k] ? disp_id_i : wr_addr_i;
        assign we   = wr_en_i && (wr_buf_i == BUF_W'(k));

        xilinx_single_port_ram #(
            .RAM_WIDTH (COLR_PXL_WIDTH),
            .RAM_DEPTH (TILE_PER_LINE),
            .ADDR_W    (LBUFF_ADDR_WIDTH)
        ) u_ram (
            .clka  (clk_i),
            .addra (addr),
            .dina  (wr_dat_i),
            .wea   (we),
            .ena   (1'b1),
            .douta (douta[k])
        );
    end

    always_comb begin
        sel_d = sel_oh_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        disp_pxl_o = '0;
        for (int k = 0; k < N_BUFFS; k++) begin
            if (sel_q[k]) begin
                disp_pxl_o = disp_pxl_o | douta[k];
            end
        end
    end

endmodule

// File: rtl/xilinx_single_port_ram.sv
// Behavioural single-port block RAM, read-first, one cycle read latency.
// No backpressure; the port accepts an access every cycle while ena is high.
module xilinx_single_port_ram #(
    parameter int RAM_WIDTH = 12,
    parameter int RAM_DEPTH = 160,
    parameter int ADDR_W    = 8
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 wea,
    input  logic                 ena,
    output logic [RAM_WIDTH-1:0] douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] dout_q;
    logic [RAM_WIDTH-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (ena) begin
            dout_d = mem[addra];
        end
    end

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
        dout_q <= dout_d;
    end

    assign douta = dout_q;

endmodule

// File: rtl/line_buffer_ring.sv
// Line-buffer ring: queued per-buffer fills from the frame buffer, served round-robin.
// One frame-buffer word per req/rsp handshake; a display read of the filling buffer stalls the write.
module line_buffer_ring
    import line_buff_pkg::*;
#(
    parameter int  N_BUFFS          = 2,
    parameter int  COLR_PXL_WIDTH   = 12,
    parameter int  WIDTH_PX         = 640,
    parameter int  TILE_WIDTH       = 4,
    parameter int  TILES_PER_ROW    = 5,
    parameter int  FBUFF_ADDR_WIDTH = 12,
    parameter int  FBUFF_DATA_WIDTH = TILES_PER_ROW * COLR_PXL_WIDTH,
    localparam int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH,
    localparam int LBUFF_ADDR_WIDTH = $clog2(TILE_PER_LINE)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_BUFFS-1:0]          fill_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] fill_row_addr_i,
    output logic [N_BUFFS-1:0]          fill_done_o,
    output logic                        fill_busy_o,
    input  logic [N_BUFFS-1:0]          buff_sel_i,
    input  logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_i,
    output logic [COLR_PXL_WIDTH-1:0]   disp_pxl_o,
    output logic                        fill_stall_o,
    output logic                        fbuff_en_o,
    output logic                        fbuff_rd_req_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
    input  logic                        fbuff_rd_rsp_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i
);

    localparam int BUF_W = (N_BUFFS > 1) ? $clog2(N_BUFFS) : 1;
    localparam int TC_W  = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;

    if ((TILE_PER_LINE % TILES_PER_ROW) != 0 || N_BUFFS < 2 || N_BUFFS > MAX_BUFFS) begin : g_bad_cfg
        $error("line_buffer_ring: line must hold whole frame-buffer words and 2..32 buffers");
    end

    fill_state_e                 state_q, state_d;
    logic [N_BUFFS-1:0]          pending_q, pending_d;
    logic [FBUFF_ADDR_WIDTH-1:0] row_addr_q [N_BUFFS];
    logic [FBUFF_ADDR_WIDTH-1:0] row_addr_d [N_BUFFS];
    logic [BUF_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [BUF_W-1:0]            cur_buf_q, cur_buf_d;
    logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_q, fbuff_addr_d;
    logic [TC_W-1:0]             tile_cnt_q, tile_cnt_d;
    logic [LBUFF_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [FBUFF_DATA_WIDTH-1:0] word_q, word_d;

    logic [MAX_BUFFS-1:0]        pend_ext;
    logic [BUF_W-1:0]            grant_idx;
    logic [N_BUFFS-1:0]          sel_oh;
    logic                        stall;
    logic                        wr_en;
    logic [COLR_PXL_WIDTH-1:0]   wr_dat;

    // Isolate the lowest set select bit so multi-hot selects resolve deterministically.
    assign sel_oh = buff_sel_i & (-buff_sel_i);
    assign stall  = (state_q == WRITE) && sel_oh[cur_buf_q];
    assign wr_en  = (state_q == WRITE) && !stall;
    assign wr_dat = word_q[tile_cnt_q * COLR_PXL_WIDTH +: COLR_PXL_WIDTH];

    always_comb begin
        pend_ext              = '0;
        pend_ext[N_BUFFS-1:0] = pending_q;
        grant_idx             = BUF_W'(rr_next(pend_ext, 32'(rr_ptr_q), 32'(N_BUFFS)));
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        row_addr_d   = row_addr_q;
        rr_ptr_d     = rr_ptr_q;
        cur_buf_d    = cur_buf_q;
        fbuff_addr_d = fbuff_addr_q;
        tile_cnt_d   = tile_cnt_q;
        wr_addr_d    = wr_addr_q;
        word_d       = word_q;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    cur_buf_d            = grant_idx;
                    pending_d[grant_idx] = 1'b0;
                    rr_ptr_d             = (grant_idx == BUF_W'(N_BUFFS - 1)) ? '0
                                                                              : grant_idx + BUF_W'(1);
                    fbuff_addr_d         = row_addr_q[grant_idx];
                    tile_cnt_d           = '0;
                    wr_addr_d            = '0;
                    state_d              = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fbuff_rd_rsp_i) begin
                    word_d  = fbuff_data_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!stall) begin
                    wr_addr_d = wr_addr_q + LBUFF_ADDR_WIDTH'(1);
                    if (tile_cnt_q == TC_W'(TILES_PER_ROW - 1)) begin
                        tile_cnt_d = '0;
                        if (wr_addr_q == LBUFF_ADDR_WIDTH'(TILE_PER_LINE - 1)) begin
                            state_d = DONE;
                        end else begin
                            fbuff_addr_d = fbuff_addr_q + FBUFF_ADDR_WIDTH'(1);
                            state_d      = REQ;
                        end
                    end else begin
                        tile_cnt_d = tile_cnt_q + TC_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New requests land after the grant clear so a re-request of the granted buffer survives.
        pending_d = pending_d | fill_req_i;
        for (int k = 0; k < N_BUFFS; k++) begin
            if (fill_req_i[k]) begin
                row_addr_d[k] = fill_row_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            cur_buf_q    <= '0;
            fbuff_addr_q <= '0;
            tile_cnt_q   <= '0;
            wr_addr_q    <= '0;
            word_q       <= '0;
            for (int k = 0; k < N_BUFFS; k++) begin
                row_addr_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_buf_q    <= cur_buf_d;
            fbuff_addr_q <= fbuff_addr_d;
            tile_cnt_q   <= tile_cnt_d;
            wr_addr_q    <= wr_addr_d;
            word_q       <= word_d;
            row_addr_q   <= row_addr_d;
        end
    end

    always_comb begin
        fill_done_o = '0;
        if (state_q == DONE) begin
            fill_done_o[cur_buf_q] = 1'b1;
        end
    end

    assign fill_busy_o    = (state_q != IDLE);
    assign fill_stall_o   = stall;
    assign fbuff_en_o     = 1'b1;
    assign fbuff_rd_req_o = (state_q == REQ);
    assign fbuff_addr_o   = fbuff_addr_q;

    lbuff_ram_bank #(
        .N_BUFFS          (N_BUFFS),
        .COLR_PXL_WIDTH   (COLR_PXL_WIDTH),
        .TILE_PER_LINE    (TILE_PER_LINE),
        .LBUFF_ADDR_WIDTH (LBUFF_ADDR_WIDTH),
        .BUF_W            (BUF_W)
    ) u_bank (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .sel_oh_i   (sel_oh),
        .disp_id_i  (disp_pxl_id_i),
        .wr_en_i    (wr_en),
        .wr_buf_i   (cur_buf_q),
        .wr_addr_i  (wr_addr_q),
        .wr_dat_i   (wr_dat),
        .disp_pxl_o (disp_pxl_o)
    );

endmodule

// File: tb/tb_line_buffer_ring.sv
// Bench for line_buffer_ring: default 2-buffer instance plus a 3-buffer, 4-tile, 8-bit instance,
// each fed by a frame-buffer responder model and checked against per-buffer expected line images.
module tb_line_buffer_ring;

    localparam int TPL = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [1:0]  a_fill_req, a_done, a_sel;
    logic [11:0] a_row, a_addr, a_pxl;
    logic [7:0]  a_id;
    logic        a_busy, a_stall, a_en, a_req, a_rsp;
    logic [59:0] a_data;

    logic [2:0]  b_fill_req, b_done, b_sel;
    logic [11:0] b_row, b_addr;
    logic [7:0]  b_id, b_pxl;
    logic        b_busy, b_stall, b_en, b_req, b_rsp;
    logic [31:0] b_data;

    line_buffer_ring u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .fill_req_i(a_fill_req), .fill_row_addr_i(a_row),
        .fill_done_o(a_done), .fill_busy_o(a_busy), .buff_sel_i(a_sel), .disp_pxl_id_i(a_id),
        .disp_pxl_o(a_pxl), .fill_stall_o(a_stall), .fbuff_en_o(a_en), .fbuff_rd_req_o(a_req),
        .fbuff_addr_o(a_addr), .fbuff_rd_rsp_i(a_rsp), .fbuff_data_i(a_data)
    );

    line_buffer_ring #(.N_BUFFS(3), .TILES_PER_ROW(4), .COLR_PXL_WIDTH(8)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .fill_req_i(b_fill_req), .fill_row_addr_i(b_row),
        .fill_done_o(b_done), .fill_busy_o(b_busy), .buff_sel_i(b_sel), .disp_pxl_id_i(b_id),
        .disp_pxl_o(b_pxl), .fill_stall_o(b_stall), .fbuff_en_o(b_en), .fbuff_rd_req_o(b_req),
        .fbuff_addr_o(b_addr), .fbuff_rd_rsp_i(b_rsp), .fbuff_data_i(b_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [59:0] fb_mem [4096];
    logic [11:0] mdl_a [2][TPL];
    logic [7:0]  mdl_b [TPL];

    // Frame-buffer responders: rsp a fixed number of cycles after each req.
    int a_cd = 0, b_cd = 0;
    logic [11:0] a_lat, b_lat;
    always @(negedge clk) begin
        a_rsp = 1'b0;
        if (a_cd > 0) begin
            a_cd--;
            if (a_cd == 0) begin
                a_rsp  = 1'b1;
                a_data = fb_mem[a_lat];
            end
        end
        if (a_req) begin
            a_cd  = 2;
            a_lat = a_addr;
        end
        b_rsp = 1'b0;
        if (b_cd > 0) begin
            b_cd--;
            if (b_cd == 0) begin
                b_rsp  = 1'b1;
                b_data = fb_mem[b_lat][31:0];
            end
        end
        if (b_req) begin
            b_cd  = 1;
            b_lat = b_addr;
        end
    end

    int          a_req_cnt = 0, a_stall_cnt = 0, b_req_cnt = 0;
    logic [11:0] a_req_q[$], b_req_q[$];
    logic [1:0]  a_done_q[$];
    int          a_done_cyc[$];
    logic [2:0]  b_done_q[$];
    always @(negedge clk) begin
        if (a_req) begin a_req_cnt++; a_req_q.push_back(a_addr); end
        if (a_stall) a_stall_cnt++;
        if (a_done != 2'b00) begin a_done_q.push_back(a_done); a_done_cyc.push_back(cyc); end
        if (b_req) begin b_req_cnt++; b_req_q.push_back(b_addr); end
        if (b_done != 3'b000) b_done_q.push_back(b_done);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Expected line image: word w of the row supplies tiles w*TPR .. w*TPR+TPR-1, tile 0 in the low bits.
    task automatic model_a(input int k, input logic [11:0] row);
        for (int w = 0; w < 32; w++)
            for (int t = 0; t < 5; t++)
                mdl_a[k][w*5+t] = fb_mem[row + 12'(w)][t*12 +: 12];
    endtask

    task automatic model_b(input logic [11:0] row);
        for (int w = 0; w < 40; w++)
            for (int t = 0; t < 4; t++)
                mdl_b[w*4+t] = fb_mem[row + 12'(w)][t*8 +: 8];
    endtask

    task automatic a_request(input logic [1:0] m, input logic [11:0] row, output int t);
        a_fill_req = m;
        a_row      = row;
        t          = cyc;
        step(1);
        a_fill_req = 2'b00;
    endtask

    task automatic a_wait_done(input int n, input string name);
        int t = 0;
        while (a_done_q.size() < n && t < 3000) begin @(negedge clk); t++; end
        chk({name, "_done_seen"}, 64'(a_done_q.size() >= n), 64'(1));
    endtask

    task automatic a_wait_nth_req(input int n, input string name);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < 3000) begin
            @(negedge clk);
            t++;
            if (a_req) seen++;
        end
        chk({name, "_req_seen"}, 64'(seen), 64'(n));
    endtask

    task automatic a_read(input logic [1:0] sel, input int id, input logic [11:0] exp, input string name);
        a_sel = sel;
        a_id  = 8'(id);
        step(1);
        @(negedge clk);
        chk(name, 64'(a_pxl), 64'(exp));
    endtask

    task automatic a_rand_reads(input int n, input logic [1:0] bufs);
        for (int i = 0; i < n; i++) begin
            int k  = bufs[0] && (!bufs[1] || $urandom_range(0, 1) == 0) ? 0 : 1;
            int id = $urandom_range(0, TPL - 1);
            a_read(k == 0 ? 2'b01 : 2'b10, id, mdl_a[k][id], $sformatf("rand_rd_b%0d_id%0d", k, id));
        end
        a_sel = 2'b00;
    endtask

    typedef struct {
        logic [1:0]  sel;
        int          id;
        logic [11:0] exp;
    } rd_vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     tbl[12];
        logic [1:0]  tsel[12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                  2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
        int          tid[12]  = '{0, 1, 4, 5, 9, 80, 158, 159, 77, 0, 159, 50};
        int          t0, t1, dbase, rbase, sbase;
        logic [11:0] rb, rc, rx, ry, rd, re, rf;

        for (int i = 0; i < 4096; i++) fb_mem[i] = {$urandom, $urandom};
        rstn = 1'b0;
        a_fill_req = '0; a_row = '0; a_sel = '0; a_id = '0; a_rsp = 1'b0; a_data = '0;
        b_fill_req = '0; b_row = '0; b_sel = '0; b_id = '0; b_rsp = 1'b0; b_data = '0;
        step(3);
        rstn = 1'b1;

        // Idle after reset.
        step(10);
        @(negedge clk);
        chk("rst_done",  64'(a_done),  64'(0));
        chk("rst_busy",  64'(a_busy),  64'(0));
        chk("rst_stall", 64'(a_stall), 64'(0));
        chk("rst_pxl",   64'(a_pxl),   64'(0));
        chk("rst_en",    64'(a_en),    64'(1));
        chk("rst_addr",  64'(a_addr),  64'(0));
        chk("rst_reqs",  64'(a_req_cnt), 64'(0));
        chk("rst_b_en",  64'(b_en),    64'(1));
        chk("rst_b_busy", 64'(b_busy), 64'(0));

        // Single fill of buffer 0 from row 0x040.
        a_request(2'b01, 12'h040, t0);
        a_wait_done(1, "fill0");
        chk("fill0_done_vec", 64'(a_done_q[0]), 64'(2'b01));
        chk("fill0_latency", 64'(a_done_cyc[0] - t0), 64'(258));
        chk("fill0_req_cnt", 64'(a_req_cnt), 64'(32));
        for (int i = 0; i < 32; i++)
            chk($sformatf("fill0_addr%0d", i), 64'(i < a_req_q.size() ? a_req_q[i] : 12'hxxx),
                64'(12'h040 + 12'(i)));
        model_a(0, 12'h040);
        step(2);
        @(negedge clk);
        chk("fill0_idle_busy", 64'(a_busy), 64'(0));
        chk("fill0_done_once", 64'(a_done_q.size()), 64'(1));

        // Fill buffer 1 while the display holds it for 7 cycles inside a WRITE burst.
        rb = 12'($urandom);
        step(1);
        a_request(2'b10, rb, t1);
        a_wait_nth_req(11, "stall");
        step(3);
        sbase = a_stall_cnt;
        a_sel = 2'b10;
        a_id  = 8'($urandom_range(0, TPL - 1));
        @(negedge clk);
        chk("stall_now",  64'(a_stall), 64'(1));
        chk("stall_busy", 64'(a_busy),  64'(1));
        step(7);
        a_sel = 2'b00;
        a_wait_done(2, "stall");
        chk("stall_cycles",   64'(a_stall_cnt - sbase), 64'(7));
        chk("stall_done_vec", 64'(a_done_q[1]), 64'(2'b10));
        chk("stall_latency",  64'(a_done_cyc[1] - t1), 64'(258 + 7));
        model_a(1, rb);

        // Read table across both buffers, select priority and deselected output.
        for (int i = 0; i < 12; i++) begin
            tbl[i].sel = tsel[i];
            tbl[i].id  = tid[i];
            tbl[i].exp = (tsel[i] == 2'b00) ? 12'h000 : (tsel[i][0] ? mdl_a[0][tid[i]] : mdl_a[1][tid[i]]);
        end
        step(1);
        for (int i = 0; i < 12; i++)
            a_read(tbl[i].sel, tbl[i].id, tbl[i].exp, $sformatf("tbl%0d_sel%0b_id%0d", i, tbl[i].sel, tbl[i].id));
        a_rand_reads(40, 2'b11);

        // Simultaneous requests: pointer back at 0, so 0 then 1.
        dbase = a_done_q.size();
        rbase = a_req_cnt;
        rc    = 12'($urandom);
        step(1);
        a_request(2'b11, rc, t0);
        a_wait_done(dbase + 2, "pair1");
        chk("pair1_first",  64'(a_done_q[dbase]),     64'(2'b01));
        chk("pair1_second", 64'(a_done_q[dbase + 1]), 64'(2'b10));
        chk("pair1_reqs",   64'(a_req_cnt - rbase),   64'(64));

        // Second pair, plus two re-requests of buffer 0 during its fill; the last address wins.
        dbase = a_done_q.size();
        rbase = a_req_q.size();
        rc    = 12'($urandom);
        rx    = 12'($urandom);
        ry    = rx ^ 12'h5A5;
        step(1);
        a_request(2'b11, rc, t0);
        step(20);
        a_request(2'b01, rx, t0);
        step(20);
        a_request(2'b01, ry, t0);
        a_wait_done(dbase + 3, "pair2");
        chk("pair2_first",  64'(a_done_q[dbase]),     64'(2'b01));
        chk("pair2_second", 64'(a_done_q[dbase + 1]), 64'(2'b10));
        chk("pair2_third",  64'(a_done_q[dbase + 2]), 64'(2'b01));
        chk("pair2_row0",   64'(a_req_q[rbase]),      64'(rc));
        chk("pair2_row1",   64'(a_req_q[rbase + 32]), 64'(rc));
        chk("pair2_rerow",  64'(a_req_q[rbase + 64]), 64'(ry));
        model_a(0, ry);
        model_a(1, rc);
        step(1);
        a_rand_reads(24, 2'b11);

        // Reset while waiting on word 10; the late response must be ignored.
        dbase = a_done_q.size();
        rbase = a_req_cnt;
        rd    = 12'($urandom);
        step(1);
        a_request(2'b01, rd, t0);
        a_wait_nth_req(11, "rstmid");
        step(1);
        #2 rstn = 1'b0;
        #1;
        chk("rstmid_busy", 64'(a_busy), 64'(0));
        chk("rstmid_req",  64'(a_req),  64'(0));
        chk("rstmid_addr", 64'(a_addr), 64'(0));
        chk("rstmid_done", 64'(a_done), 64'(0));
        step(1);
        rstn = 1'b1;
        step(10);
        @(negedge clk);
        chk("rstmid_idle",    64'(a_busy), 64'(0));
        chk("rstmid_no_done", 64'(a_done_q.size()), 64'(dbase));
        chk("rstmid_no_reqs", 64'(a_req_cnt - rbase), 64'(11));
        re    = 12'($urandom);
        rbase = a_req_q.size();
        step(1);
        a_request(2'b10, re, t0);
        a_wait_done(dbase + 1, "rstmid_refill");
        chk("refill_done_vec", 64'(a_done_q[dbase]), 64'(2'b10));
        chk("refill_row",      64'(a_req_q[rbase]),  64'(re));
        chk("refill_reqs",     64'(a_req_q.size() - rbase), 64'(32));
        model_a(1, re);
        step(1);
        a_rand_reads(10, 2'b10);

        // Three-buffer, 4-tile, 8-bit instance: fill buffer 1, read with a multi-hot select.
        rf = 12'($urandom);
        model_b(rf);
        step(1);
        b_fill_req = 3'b010;
        b_row      = rf;
        step(1);
        b_fill_req = 3'b000;
        begin
            int t = 0;
            while (b_done_q.size() < 1 && t < 3000) begin @(negedge clk); t++; end
        end
        chk("b_done_seen", 64'(b_done_q.size()), 64'(1));
        chk("b_done_vec",  64'(b_done_q.size() > 0 ? b_done_q[0] : 3'b000), 64'(3'b010));
        chk("b_req_cnt",   64'(b_req_cnt), 64'(40));
        chk("b_first_row", 64'(b_req_q.size() > 0  ? b_req_q[0]  : 12'hxxx), 64'(rf));
        chk("b_last_row",  64'(b_req_q.size() > 39 ? b_req_q[39] : 12'hxxx), 64'(rf + 12'd39));
        for (int i = 0; i < 16; i++) begin
            int id = (i == 0) ? 0 : (i == 1) ? TPL - 1 : (i == 2) ? 3 : $urandom_range(0, TPL - 1);
            b_sel = 3'b110;
            b_id  = 8'(id);
            step(1);
            @(negedge clk);
            chk($sformatf("b_rd_id%0d", id), 64'(b_pxl), 64'(mdl_b[id]));
        end
        b_sel = 3'b000;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
